// File: rtl/mul_share_pkg.sv
// mul_share_pkg
//   Shared constants and record types for the multiplier-sharing arbiter.
//   DATA_W      : operand / product width of the shared multiplier
//   MUL_LATENCY : default multiplier latency in cycles
//   ID_W        : default requester-ID width (four requesters)
//   mul_tag_t   : in-flight tag travelling alongside the multiplier pipeline
//   resp_ent_t  : one result FIFO entry (truncated product plus requester ID)
package mul_share_pkg;

  localparam int DATA_W      = 8;
  localparam int MUL_LATENCY = 3;
  localparam int ID_W        = 2;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } mul_tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } resp_ent_t;

endpackage

// File: rtl/mul_share_resp_fifo.sv
// mul_share_resp_fifo
//   Synchronous in-order FIFO of resp_ent_t entries holding multiplier results
//   until the response consumer takes them.
// Ports
//   clock    in   rising-edge clock
//   reset_n  in   synchronous reset, active low (empties the FIFO)
//   push     in   write push_ent at this edge (caller guarantees space)
//   push_ent in   entry to write
//   pop      in   remove the head entry at this edge (ignored when empty)
//   head     out  oldest entry; all zero while empty
//   empty    out  no entries stored
//   count    out  number of stored entries
module mul_share_resp_fifo
  import mul_share_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  resp_ent_t        push_ent,
  input  logic             pop,
  output resp_ent_t        head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_ent_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  // Pointers wrap explicitly so that non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign empty  = (count == '0);
  assign pop_ok = pop & ~empty;
  // Zero the head while empty so the response outputs idle at zero.
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one externally instantiated pipelined 8-bit multiplier between
//   NUM_REQ requesters. Round-robin issue of one operand pair per cycle, an
//   ID tag pipe that tracks each product through the multiplier, and a
//   credit-guarded result FIFO that returns tagged products in issue order.
// Optional feature (macro MUL_SHARE_STATS_EN): adds saturating 16-bit
//   stat_issue (handshakes) and stat_stall (cycles with a request pending
//   but no handshake) outputs.
// Ports
//   clock      in   rising-edge clock
//   reset_n    in   synchronous reset, active low
//   req_valid  in   per-requester operand valid
//   req_ready  out  per-requester grant, one-hot or zero
//   req_a      in   operand A, requester i at [8i+7:8i]
//   req_b      in   operand B, same packing
//   mul_I0     out  multiplier operand 0 (zero when nothing issues)
//   mul_I1     out  multiplier operand 1 (zero when nothing issues)
//   mul_O      in   multiplier product, MUL_LATENCY cycles after issue
//   resp_valid out  response valid
//   resp_ready in   response consumer ready
//   resp_data  out  product[7:0]
//   resp_id    out  requester that issued this product
//   stat_issue out  (MUL_SHARE_STATS_EN only) handshake count
//   stat_stall out  (MUL_SHARE_STATS_EN only) stalled-request cycle count
module mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = mul_share_pkg::ID_W,
  parameter int RESP_DEPTH  = 4,
  parameter int MUL_LATENCY = mul_share_pkg::MUL_LATENCY
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*8-1:0] req_a,
  input  logic [NUM_REQ*8-1:0] req_b,
  output logic [7:0]           mul_I0,
  output logic [7:0]           mul_I1,
  input  logic [7:0]           mul_O,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [7:0]           resp_data,
  output logic [ID_W-1:0]      resp_id
`ifdef MUL_SHARE_STATS_EN
  ,
  output logic [15:0]          stat_issue,
  output logic [15:0]          stat_stall
`endif
);

  import mul_share_pkg::*;

  localparam int FC_W = $clog2(RESP_DEPTH + 1);
  localparam int CR_W = $clog2(RESP_DEPTH + MUL_LATENCY + 1) + 1;

  // Both request and response channels use strict valid/ready semantics:
  // a transfer happens on a rising edge where valid and ready are both 1.
  // A requester keeps its operands stable while valid is high and not yet
  // granted; resp_* stay stable while resp_valid is high and resp_ready low.

  logic [7:0]      lane_a [NUM_REQ];
  logic [7:0]      lane_b [NUM_REQ];
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] ptr_next;
  logic            grant_found;
  logic            credit_ok;
  logic            hs;
  logic            pop;
  logic [CR_W-1:0] in_use;
  mul_tag_t        tag_q [MUL_LATENCY];
  logic [FC_W-1:0] fifo_count;
  logic            fifo_empty;
  resp_ent_t       fifo_head;
  resp_ent_t       push_ent;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_a[i] = req_a[8*i +: 8];
    assign lane_b[i] = req_b[8*i +: 8];
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [ID_W:0] cand;
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Every tagged stage and every stored entry holds a credit. The stage-final
  // tag is still counted: it becomes a FIFO entry at the coming edge.
  always_comb begin
    in_use = CR_W'(fifo_count);
    for (int s = 0; s < MUL_LATENCY; s++) begin
      in_use = in_use + CR_W'(tag_q[s].vld);
    end
  end

  assign pop       = resp_valid & resp_ready;
  // A pop in this cycle frees its credit for an issue in the same cycle.
  assign credit_ok = (in_use - CR_W'(pop)) < CR_W'(RESP_DEPTH);
  // No grant while reset is asserted: the tag would be discarded anyway.
  assign hs        = reset_n & credit_ok & grant_found;

  assign req_ready = hs ? (NUM_REQ'(1) << grant_idx) : '0;
  assign mul_I0    = hs ? lane_a[grant_idx] : 8'd0;
  assign mul_I1    = hs ? lane_b[grant_idx] : 8'd0;

  // Tag pipe runs in lockstep with the multiplier; the last stage lines up
  // with the product of that operand pair on mul_O.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      for (int s = 0; s < MUL_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      if (hs) begin
        rr_ptr <= ptr_next;
      end
      tag_q[0] <= '{vld: hs, id: grant_idx};
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign push_ent = '{data: mul_O, id: tag_q[MUL_LATENCY-1].id};

  mul_share_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (tag_q[MUL_LATENCY-1].vld),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign resp_valid = ~fifo_empty;
  assign resp_data  = fifo_head.data;
  assign resp_id    = fifo_head.id;

`ifdef MUL_SHARE_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_issue <= '0;
      stat_stall <= '0;
    end else begin
      if (hs && stat_issue != 16'hFFFF) begin
        stat_issue <= stat_issue + 16'd1;
      end
      if ((|req_valid) && !hs && stat_stall != 16'hFFFF) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Directed bench for mul_share_arbiter with a 3-cycle multiplier model.
//   Single-op vectors are table driven; round-robin, credit exhaustion and
//   reset-mid-flight are hand-written sequences. A scoreboard compares every
//   accepted response with the expected queue.
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clock;
  logic                 reset_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [7:0]           mul_I0;
  logic [7:0]           mul_I1;
  logic [7:0]           mul_O;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [7:0]           resp_data;
  logic [ID_W-1:0]      resp_id;
`ifdef MUL_SHARE_STATS_EN
  logic [15:0]          stat_issue;
  logic [15:0]          stat_stall;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    int         r;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  mul_share_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .mul_I0     (mul_I0),
    .mul_I1     (mul_I1),
    .mul_O      (mul_O),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
`ifdef MUL_SHARE_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Pipelined multiplier model: 3 cycles, no enable, no reset.
  logic [7:0] m0, m1, m2;
  always @(posedge clock) begin
    m0 <= mul_I0 * mul_I1;
    m1 <= m0;
    m2 <= m1;
  end
  assign mul_O = m2;

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic push_exp(input int id, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [1:0]  id2;
    p   = {8'd0, a} * {8'd0, b};
    id2 = id[1:0];
    exp_q.push_back({id2, p[7:0]});
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    tick();
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
      @(negedge clock);
    end
    tick();
    check(name, 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    check({name, "_idle"}, 32'(resp_valid), 32'd0);
    tick();
  endtask

  // One isolated op: grant and operands in cycle t, resp exactly at t+4.
  task automatic run_single(input int r, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_data);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    set_lane(r, a, b);
    push_exp(r, a, b);
    @(negedge clock);
    check("single_grant", 32'(req_ready), 32'd1 << r);
    check("single_mul_I0", 32'(mul_I0), 32'(a));
    check("single_mul_I1", 32'(mul_I1), 32'(b));
    tick();
    req_valid = '0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      check("single_early_valid", 32'(resp_valid), 32'd0);
      if (k == 1) check("single_idle_mul_I0", 32'(mul_I0), 32'd0);
      tick();
    end
    @(negedge clock);
    check("single_resp_valid", 32'(resp_valid), 32'd1);
    check("single_resp_data", 32'(resp_data), 32'(exp_data));
    check("single_resp_id", 32'(resp_id), 32'(r));
    tick();
    @(negedge clock);
    check("single_no_extra", 32'(resp_valid), 32'd0);
    tick();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (reset_n) begin
      check("req_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got id=%0d data=%0d, required no response",
                   resp_id, resp_data);
        end else begin
          check("sb_resp", {22'd0, resp_id, resp_data}, {22'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{0, 8'd7,   8'd6,   8'd42};
    vecs[1] = '{2, 8'd200, 8'd2,   8'd144};
    vecs[2] = '{1, 8'd255, 8'd255, 8'd1};
    vecs[3] = '{3, 8'd16,  8'd16,  8'd0};
    vecs[4] = '{1, 8'd0,   8'd99,  8'd0};
    vecs[5] = '{3, 8'd13,  8'd11,  8'd143};

    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_mul_I0", 32'(mul_I0), 32'd0);
    check("rst_mul_I1", 32'(mul_I1), 32'd0);
`ifdef MUL_SHARE_STATS_EN
    check("rst_stat_issue", 32'(stat_issue), 32'd0);
    check("rst_stat_stall", 32'(stat_stall), 32'd0);
`endif
    tick();

    // Single-op vectors
    for (int v = 0; v < 6; v++) begin
      run_single(vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].exp_data);
    end

    // Round robin, all requesters valid, consumer always ready
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 8'(10 + i), 8'(3 + i));
    req_valid = '1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check("rr_grant", 32'(req_ready), 32'd1 << (c % 4));
      push_exp(c % 4, 8'(10 + c % 4), 8'(3 + c % 4));
      tick();
    end
    req_valid = '0;
    drain("rr_drain");

    // Credit exhaustion with consumer stalled, then one issue per pop
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 8'(20 + 3 * i), 8'(7 + i));
    resp_ready = 1'b0;
    req_valid  = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("full_grant", 32'(req_ready), (c < 4) ? (32'd1 << c) : 32'd0);
      if (c < 4) push_exp(c, 8'(20 + 3 * c), 8'(7 + c));
      if (c >= 4) begin
        check("full_hold_valid", 32'(resp_valid), 32'd1);
        check("full_hold_data", 32'(resp_data), 32'd140);
        check("full_hold_id", 32'(resp_id), 32'd0);
      end
      tick();
    end
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
`ifdef MUL_SHARE_STATS_EN
      if (k == 0) begin
        check("stat_issue", 32'(stat_issue), 32'd4);
        check("stat_stall", 32'(stat_stall), 32'd6);
      end
`endif
      check("credit_grant", 32'(req_ready), 32'd1 << k);
      push_exp(k, 8'(20 + 3 * k), 8'(7 + k));
      tick();
    end
    req_valid = '0;
    drain("full_drain");

    // Reset in the middle of three in-flight ops
    req_valid    = '0;
    req_valid[1] = 1'b1;
    set_lane(1, 8'd5, 8'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("pre_reset_grant", 32'(req_ready), 32'd2);
      tick();
    end
    do_reset();
    @(negedge clock);
    check("post_rst_req_ready", 32'(req_ready), 32'd0);
    check("post_rst_mul_I0", 32'(mul_I0), 32'd0);
    check("post_rst_resp_data", 32'(resp_data), 32'd0);
    check("post_rst_resp_id", 32'(resp_id), 32'd0);
    tick();
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check("post_rst_no_resp", 32'(resp_valid), 32'd0);
      tick();
    end
    run_single(3, 8'd9, 8'd9, 8'd81);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
